// File: rtl/pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// pll_lock_ctrl
//
// Reset and lock sequencer for an ECP5 EHXPLLL. It pulses the PLL RST input,
// waits for LOCK with a timeout, and checks that lock stays stable before it
// raises `ready`. `ready` gates the downstream clock-domain resets. Lock loss is
// monitored and the controller recovers automatically. It runs on the PLL
// reference clock, because the PLL outputs cannot be trusted before lock.
//
// Optional feature, macro PLL_PHASE_STEP_EN:
//   defined   - a dynamic-phase step engine drives PHASESEL/PHASEDIR/PHASESTEP
//               through a phase_req/phase_ack handshake (states PH_SET/PH_HI/PH_LO).
//   undefined - the engine is absent. The phase inputs are ignored and the
//               phase outputs are tied low. The port list is the same.
//
// Parameters:
//   RST_CYCLES  - cycles pll_rst is held high per reset pulse (>=1)
//   LOCK_WAIT   - cycles to wait for lock before timing out (>=1)
//   LOCK_STABLE - consecutive synchronized-lock cycles required before ready (>=1)
//   PHASE_PULSE - setup / step-high / step-low width in cycles (>=1)
//
// Ports:
//   clk           in  PLL reference clock (same net as CLKI)
//   rst           in  asynchronous active-high reset
//   pll_lock      in  raw PLL LOCK (asynchronous to clk)
//   restart       in  single-cycle request to re-run the full sequence
//   phase_req     in  phase-step request level, held until phase_ack
//   phase_sel[1:0]in  output select, sampled when the step is accepted
//   phase_dir     in  step direction, sampled when the step is accepted
//   pll_rst       out to PLL RST
//   ready         out PLL locked and stable
//   fail          out sticky lock-timeout indicator
//   relock_count  out saturating count of lock-loss events
//   pll_phasesel  out to PLL PHASESEL1:0
//   pll_phasedir  out to PLL PHASEDIR
//   pll_phasestep out to PLL PHASESTEP
//   phase_ack     out one-cycle pulse when a step completes
// -----------------------------------------------------------------------------
module pll_lock_ctrl #(
    parameter int RST_CYCLES  = 16,
    parameter int LOCK_WAIT   = 65535,
    parameter int LOCK_STABLE = 255,
    parameter int PHASE_PULSE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       restart,
    input  logic       phase_req,
    input  logic [1:0] phase_sel,
    input  logic       phase_dir,
    output logic       pll_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] relock_count,
    output logic [1:0] pll_phasesel,
    output logic       pll_phasedir,
    output logic       pll_phasestep,
    output logic       phase_ack
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One shared counter; its width comes from the largest terminal value.
    localparam int CNT_MAX = max2(max2(RST_CYCLES, LOCK_WAIT), max2(LOCK_STABLE, PHASE_PULSE));
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TC_RST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_WAIT = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] TC_STAB = CNT_W'(LOCK_STABLE - 1);

`ifdef PLL_PHASE_STEP_EN
    localparam logic [CNT_W-1:0] TC_PH   = CNT_W'(PHASE_PULSE - 1);
    // PH_LO lasts one cycle longer than the other two phases. This puts the
    // phase_ack edge 3*PHASE_PULSE+2 edges after the request is accepted.
    localparam logic [CNT_W-1:0] TC_PHLO = CNT_W'(PHASE_PULSE);

    typedef enum logic [2:0] {
        S_RSTP, S_WAITL, S_STAB, S_RDY, S_PH_SET, S_PH_HI, S_PH_LO
    } state_t;
`else
    typedef enum logic [1:0] {
        S_RSTP, S_WAITL, S_STAB, S_RDY
    } state_t;
`endif

    // ---------------- lock synchronizer ----------------
    logic [1:0] r_lock_sync;
    logic       w_lock_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lock_sync <= 2'b00;
        end else begin
            r_lock_sync <= {r_lock_sync[0], pll_lock};
        end
    end

    assign w_lock_s = r_lock_sync[1];

    // ---------------- state and registered outputs ----------------
    state_t           r_state,  w_state_next;
    logic [CNT_W-1:0] r_cnt,    w_cnt_next;
    logic             r_pll_rst, w_pll_rst_next;
    logic             r_ready,  w_ready_next;
    logic             r_fail,   w_fail_next;
    logic [7:0]       r_relock, w_relock_next;
    logic [7:0]       w_relock_sat;

    assign w_relock_sat = (r_relock == 8'hFF) ? 8'hFF : r_relock + 8'd1;

`ifdef PLL_PHASE_STEP_EN
    logic [1:0] r_phasesel,  w_phasesel_next;
    logic       r_phasedir,  w_phasedir_next;
    logic       r_phasestep, w_phasestep_next;
    logic       r_phase_ack, w_phase_ack_next;
`else
    logic w_unused_phase;
    assign w_unused_phase = ^{phase_req, phase_sel, phase_dir};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RSTP;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_fail    <= 1'b0;
            r_relock  <= 8'd0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pll_rst <= w_pll_rst_next;
            r_ready   <= w_ready_next;
            r_fail    <= w_fail_next;
            r_relock  <= w_relock_next;
        end
    end

`ifdef PLL_PHASE_STEP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phasesel  <= 2'b00;
            r_phasedir  <= 1'b0;
            r_phasestep <= 1'b0;
            r_phase_ack <= 1'b0;
        end else begin
            r_phasesel  <= w_phasesel_next;
            r_phasedir  <= w_phasedir_next;
            r_phasestep <= w_phasestep_next;
            r_phase_ack <= w_phase_ack_next;
        end
    end
`endif

    // ---------------- next-state logic ----------------
    // Each cycle the priority is: restart, then lock loss, then timeout, then phase_req.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt + 1'b1;
        w_fail_next   = r_fail;
        w_relock_next = r_relock;
`ifdef PLL_PHASE_STEP_EN
        w_phasesel_next  = r_phasesel;
        w_phasedir_next  = r_phasedir;
        w_phasestep_next = 1'b0;
        w_phase_ack_next = 1'b0;
`endif

        if (restart) begin
            w_state_next = S_RSTP;
            w_cnt_next   = '0;
            w_fail_next  = 1'b0;
        end else begin
            case (r_state)
                S_RSTP: begin
                    if (r_cnt == TC_RST) begin
                        w_state_next = S_WAITL;
                        w_cnt_next   = '0;
                    end
                end
                S_WAITL: begin
                    if (w_lock_s) begin
                        w_state_next = S_STAB;
                        w_cnt_next   = '0;
                    end else if (r_cnt == TC_WAIT) begin
                        w_fail_next  = 1'b1;
                        w_state_next = S_RSTP;
                        w_cnt_next   = '0;
                    end
                end
                S_STAB: begin
                    // A glitch returns to WAITL, so both the timeout and the
                    // stability count start again from zero.
                    if (!w_lock_s) begin
                        w_state_next = S_WAITL;
                        w_cnt_next   = '0;
                    end else if (r_cnt == TC_STAB) begin
                        w_state_next = S_RDY;
                        w_cnt_next   = '0;
                    end
                end
                S_RDY: begin
                    w_cnt_next = '0;
                    if (!w_lock_s) begin
                        w_relock_next = w_relock_sat;
                        w_state_next  = S_RSTP;
`ifdef PLL_PHASE_STEP_EN
                    end else if (phase_req) begin
                        w_state_next    = S_PH_SET;
                        w_phasesel_next = phase_sel;
                        w_phasedir_next = phase_dir;
`endif
                    end
                end
`ifdef PLL_PHASE_STEP_EN
                // Lock loss in any phase state aborts the step. phasestep drops
                // because its default is 0, and no ack is sent.
                S_PH_SET: begin
                    if (!w_lock_s) begin
                        w_relock_next = w_relock_sat;
                        w_state_next  = S_RSTP;
                        w_cnt_next    = '0;
                    end else if (r_cnt == TC_PH) begin
                        w_state_next     = S_PH_HI;
                        w_cnt_next       = '0;
                        w_phasestep_next = 1'b1;
                    end
                end
                S_PH_HI: begin
                    if (!w_lock_s) begin
                        w_relock_next = w_relock_sat;
                        w_state_next  = S_RSTP;
                        w_cnt_next    = '0;
                    end else if (r_cnt == TC_PH) begin
                        w_state_next = S_PH_LO;
                        w_cnt_next   = '0;
                    end else begin
                        w_phasestep_next = 1'b1;
                    end
                end
                S_PH_LO: begin
                    if (!w_lock_s) begin
                        w_relock_next = w_relock_sat;
                        w_state_next  = S_RSTP;
                        w_cnt_next    = '0;
                    end else if (r_cnt == TC_PHLO) begin
                        w_state_next     = S_RDY;
                        w_cnt_next       = '0;
                        w_phase_ack_next = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_next = S_RSTP;
                    w_cnt_next   = '0;
                end
            endcase
        end

        // The outputs are registered from the next state, so they change on
        // the same edge as the state.
        w_pll_rst_next = (w_state_next == S_RSTP);
        w_ready_next   = (w_state_next != S_RSTP) && (w_state_next != S_WAITL) &&
                         (w_state_next != S_STAB);
    end

    assign pll_rst      = r_pll_rst;
    assign ready        = r_ready;
    assign fail         = r_fail;
    assign relock_count = r_relock;

`ifdef PLL_PHASE_STEP_EN
    assign pll_phasesel  = r_phasesel;
    assign pll_phasedir  = r_phasedir;
    assign pll_phasestep = r_phasestep;
    assign phase_ack     = r_phase_ack;
`else
    assign pll_phasesel  = 2'b00;
    assign pll_phasedir  = 1'b0;
    assign pll_phasestep = 1'b0;
    assign phase_ack     = 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for pll_lock_ctrl. Expected edge counts come from the timing rules
// of the block: pll_rst width, lock-to-ready, loss-to-not-ready, timeout and
// the phase step. A small model tracks the saturating relock count. Delays,
// glitch positions and phase selects are randomized.
// -----------------------------------------------------------------------------
module tb_pll_lock_ctrl;

    localparam int RC = 16;
    localparam int LW = 1000;
    localparam int LS = 40;
    localparam int PP = 4;
`ifdef PLL_PHASE_STEP_EN
    localparam bit PH_EN = 1'b1;
`else
    localparam bit PH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       restart;
    logic       phase_req;
    logic [1:0] phase_sel;
    logic       phase_dir;
    logic       pll_rst, ready, fail;
    logic [7:0] relock_count;
    logic [1:0] pll_phasesel;
    logic       pll_phasedir, pll_phasestep, phase_ack;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_relock = 0;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .RST_CYCLES (RC),
        .LOCK_WAIT  (LW),
        .LOCK_STABLE(LS),
        .PHASE_PULSE(PP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .restart      (restart),
        .phase_req    (phase_req),
        .phase_sel    (phase_sel),
        .phase_dir    (phase_dir),
        .pll_rst      (pll_rst),
        .ready        (ready),
        .fail         (fail),
        .relock_count (relock_count),
        .pll_phasesel (pll_phasesel),
        .pll_phasedir (pll_phasedir),
        .pll_phasestep(pll_phasestep),
        .phase_ack    (phase_ack)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Edges until pll_rst is low. Returns -1 if the bound runs out.
    task automatic wait_prst_low(output int n);
        n = 0;
        while (pll_rst !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (pll_rst !== 1'b0) n = -1;
    endtask

    // Edges until ready == v. Returns -1 if the bound runs out.
    task automatic wait_ready(input logic v, output int n);
        n = 0;
        while (ready !== v && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (ready !== v) n = -1;
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    // Raise lock just after RSTP has finished and time the rise of ready.
    task automatic relock(input string tag);
        int n;
        pll_lock = 1'b1;
        wait_ready(1'b1, n);
        n_checks++;
        if (n !== LS + 3) begin
            n_fail++;
            $display("FAIL %s_lock_to_ready: got %0d edges, expected %0d", tag, n, LS + 3);
        end
    endtask

    task automatic test_reset();
        logic [15:0] got;
        int n;
        rst = 1'b1; pll_lock = 1'b0; restart = 1'b0;
        phase_req = 1'b0; phase_sel = 2'b00; phase_dir = 1'b0;
        tick(3);
        got = {pll_rst, ready, fail, relock_count, pll_phasesel, pll_phasedir, pll_phasestep, phase_ack};
        n_checks++;
        if (got !== 16'b1_0_0_00000000_00_0_0_0) begin
            n_fail++;
            $display("FAIL reset_values: got %h, expected %h", got, 16'b1_0_0_00000000_00_0_0_0);
        end
        rst = 1'b0;
        wait_prst_low(n);
        n_checks++;
        if (n !== RC) begin
            n_fail++;
            $display("FAIL reset_prst_width: got %0d, expected %0d", n, RC);
        end
        $display("test_reset: pll_rst width %0d", n);
    endtask

    task automatic test_nominal_lock();
        int n;
        tick(100 - RC + $urandom_range(0, 20));
        pll_lock = 1'b1;
        wait_ready(1'b1, n);
        n_checks++;
        if (n !== LS + 3) begin
            n_fail++;
            $display("FAIL nominal_lock_to_ready: got %0d, expected %0d", n, LS + 3);
        end
        n_checks++;
        if ({fail, pll_rst} !== 2'b00) begin
            n_fail++;
            $display("FAIL nominal_fail_prst: got %b, expected 00", {fail, pll_rst});
        end
        $display("test_nominal_lock: ready after %0d edges", n);
    endtask

    task automatic test_glitch_stab();
        int n;
        int d;
        pll_lock = 1'b0; restart = 1'b1;
        tick(1);
        restart = 1'b0;
        wait_prst_low(n);
        n_checks++;
        if (n !== RC) begin
            n_fail++;
            $display("FAIL glitch_restart_prst: got %0d, expected %0d", n, RC);
        end
        pll_lock = 1'b1;
        d = $urandom_range(1, LS - 1);
        tick(d);
        pll_lock = 1'b0;
        tick(1);
        pll_lock = 1'b1;
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch_ready_early: got %b, expected 0", ready);
        end
        wait_ready(1'b1, n);
        n_checks++;
        if (n !== LS + 3) begin
            n_fail++;
            $display("FAIL glitch_full_recount: got %0d, expected %0d", n, LS + 3);
        end
        n_checks++;
        if (relock_count !== 8'(exp_relock)) begin
            n_fail++;
            $display("FAIL glitch_relock_count: got %0d, expected %0d", relock_count, exp_relock);
        end
        $display("test_glitch_stab: glitch at %0d, ready %0d edges after recovery", d, n);
    endtask

    task automatic test_lock_loss(input int iters);
        int n;
        for (int it = 0; it < iters; it++) begin
            if (n_fail > 20) break;
            tick($urandom_range(1, 8));
            pll_lock = 1'b0;
            tick(2);
            n_checks++;
            if (ready !== 1'b1) begin
                n_fail++;
                $display("FAIL loss_ready_held: iter %0d got %b, expected 1", it, ready);
            end
            tick(1);
            n_checks++;
            if ({ready, pll_rst} !== 2'b01) begin
                n_fail++;
                $display("FAIL loss_ready_drop: iter %0d got %b, expected 01", it, {ready, pll_rst});
            end
            exp_relock = sat_inc(exp_relock);
            n_checks++;
            if (relock_count !== 8'(exp_relock)) begin
                n_fail++;
                $display("FAIL loss_relock_count: iter %0d got %0d, expected %0d", it, relock_count, exp_relock);
            end
            wait_prst_low(n);
            n_checks++;
            if (n !== RC) begin
                n_fail++;
                $display("FAIL loss_prst_width: iter %0d got %0d, expected %0d", it, n, RC);
            end
            relock("loss");
            $display("test_lock_loss: iter %0d relock_count %0d", it, relock_count);
        end
    endtask

    task automatic test_restart_with_loss();
        int n;
        pll_lock = 1'b0;
        tick(2);
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_checks++;
        if ({ready, pll_rst, fail} !== 3'b010) begin
            n_fail++;
            $display("FAIL restart_loss_outputs: got %b, expected 010", {ready, pll_rst, fail});
        end
        n_checks++;
        if (relock_count !== 8'(exp_relock)) begin
            n_fail++;
            $display("FAIL restart_loss_relock: got %0d, expected %0d", relock_count, exp_relock);
        end
        wait_prst_low(n);
        n_checks++;
        if (n !== RC) begin
            n_fail++;
            $display("FAIL restart_prst_width: got %0d, expected %0d", n, RC);
        end
        relock("restart");
        $display("test_restart_with_loss: relock_count %0d", relock_count);
    endtask

    task automatic test_phase(input logic [1:0] s, input logic d);
        logic [5:0] got, want;
        logic [1:0] es;
        logic       ed;
        es = PH_EN ? s : 2'b00;
        ed = PH_EN ? d : 1'b0;
        phase_sel = s; phase_dir = d; phase_req = 1'b1;
        for (int k = 1; k <= 3 * PP + 2; k++) begin
            tick(1);
            if (k == 1) begin
                phase_sel = ~s;
                phase_dir = ~d;
            end
            got  = {pll_phasesel, pll_phasedir, pll_phasestep, phase_ack, ready};
            want = {es, ed, (PH_EN && k >= PP + 1 && k <= 2 * PP), (PH_EN && k == 3 * PP + 2), 1'b1};
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL phase_edge_%0d: got sel/dir/step/ack/ready %b, expected %b", k, got, want);
            end
        end
        phase_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            n_checks++;
            if ({pll_phasestep, phase_ack, ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL phase_after_ack_%0d: got %b, expected 001", k, {pll_phasestep, phase_ack, ready});
            end
        end
        $display("test_phase: sel %0d dir %0d engine %0d", s, d, PH_EN);
    endtask

`ifdef PLL_PHASE_STEP_EN
    task automatic test_abort();
        int   n;
        logic ack_seen;
        phase_sel = 2'($urandom_range(0, 3));
        phase_dir = 1'($urandom_range(0, 1));
        phase_req = 1'b1;
        tick(1 + PP);
        n_checks++;
        if (pll_phasestep !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_step_high: got %b, expected 1", pll_phasestep);
        end
        pll_lock = 1'b0;
        tick(2);
        n_checks++;
        if ({pll_phasestep, ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL abort_before_loss: got %b, expected 11", {pll_phasestep, ready});
        end
        tick(1);
        n_checks++;
        if ({pll_phasestep, ready, pll_rst} !== 3'b001) begin
            n_fail++;
            $display("FAIL abort_step_drop: got %b, expected 001", {pll_phasestep, ready, pll_rst});
        end
        exp_relock = sat_inc(exp_relock);
        n_checks++;
        if (relock_count !== 8'(exp_relock)) begin
            n_fail++;
            $display("FAIL abort_relock_count: got %0d, expected %0d", relock_count, exp_relock);
        end
        phase_req = 1'b0;
        ack_seen = phase_ack;
        n = 0;
        while (pll_rst !== 1'b0 && n < 5000) begin
            tick(1);
            n++;
            if (phase_ack) ack_seen = 1'b1;
        end
        n_checks++;
        if (n !== RC) begin
            n_fail++;
            $display("FAIL abort_prst_width: got %0d, expected %0d", n, RC);
        end
        n_checks++;
        if (ack_seen !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_ack: got %b, expected 0", ack_seen);
        end
        relock("abort");
        $display("test_abort: relock_count %0d", relock_count);
    endtask
`endif

    task automatic test_timeout();
        int n;
        pll_lock = 1'b0; restart = 1'b1;
        tick(1);
        restart = 1'b0;
        wait_prst_low(n);
        n_checks++;
        if (n !== RC) begin
            n_fail++;
            $display("FAIL timeout_first_prst: got %0d, expected %0d", n, RC);
        end
        n = 0;
        while (fail !== 1'b1 && n < 3000) begin
            tick(1);
            n++;
        end
        n_checks++;
        if (n !== LW) begin
            n_fail++;
            $display("FAIL timeout_fail_edge: got %0d, expected %0d", n, LW);
        end
        n_checks++;
        if (pll_rst !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_prst_repulse: got %b, expected 1", pll_rst);
        end
        wait_prst_low(n);
        n_checks++;
        if (n !== RC) begin
            n_fail++;
            $display("FAIL timeout_retry_prst: got %0d, expected %0d", n, RC);
        end
        tick($urandom_range(1, 50));
        n_checks++;
        if (fail !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b, expected 1", fail);
        end
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        n_checks++;
        if ({fail, pll_rst} !== 2'b01) begin
            n_fail++;
            $display("FAIL timeout_restart_clears: got %b, expected 01", {fail, pll_rst});
        end
        wait_prst_low(n);
        relock("timeout");
        $display("test_timeout: fail cleared by restart");
    endtask

    task automatic test_async_reset();
        logic [15:0] got;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        got = {pll_rst, ready, fail, relock_count, pll_phasesel, pll_phasedir, pll_phasestep, phase_ack};
        n_checks++;
        if (got !== 16'b1_0_0_00000000_00_0_0_0) begin
            n_fail++;
            $display("FAIL async_reset_values: got %h, expected %h", got, 16'b1_0_0_00000000_00_0_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("test_async_reset: done");
    endtask

    initial begin
        test_reset();
        test_nominal_lock();
        test_glitch_stab();
        test_lock_loss(5);
        test_restart_with_loss();
        test_phase(2'd2, 1'b1);
        test_phase(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
`ifdef PLL_PHASE_STEP_EN
        test_abort();
`endif
        test_timeout();
        test_lock_loss(300);
        n_checks++;
        if (relock_count !== 8'd255) begin
            n_fail++;
            $display("FAIL relock_saturation: got %0d, expected 255", relock_count);
        end
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
